// File: rtl/i2s_tx_scheduler.sv
// I2S transmit frame scheduler: generates bclk/lrclk, shift strobes and per-frame loads,
// and arbitrates two stereo sources onto one serializer once per frame.
module i2s_tx_scheduler #(
    parameter int DATA_W    = 32,
    parameter int CLK_DIV   = 4,
    parameter bit HOLD_LAST = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic              s0_valid,
    output logic              s0_ready,
    input  logic [DATA_W-1:0] s0_left,
    input  logic [DATA_W-1:0] s0_right,
    input  logic              s1_valid,
    output logic              s1_ready,
    input  logic [DATA_W-1:0] s1_left,
    input  logic [DATA_W-1:0] s1_right,
    input  logic              clr_stats,
    output logic              bclk,
    output logic              lrclk,
    output logic              bit_strobe,
    output logic              tx_load,
    output logic [DATA_W-1:0] tx_left,
    output logic [DATA_W-1:0] tx_right,
    output logic              tx_src,
    output logic              active,
    output logic              underrun,
    output logic [15:0]       underrun_cnt
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = $clog2(2 * DATA_W);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(2 * DATA_W - 1);
    localparam logic [BW-1:0] LR_LO    = BW'(DATA_W - 1);
    localparam logic [BW-1:0] LR_HI    = BW'(2 * DATA_W - 2);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_t;

    state_t          state;
    logic [DW-1:0]   div_cnt;
    logic [BW-1:0]   bit_cnt;
    logic [BW-1:0]   bit_nxt;
    logic            lr_nxt;
    logic            last_grant;
    logic            frame_end;
    logic            decide;
    logic            grant;
    logic            xfer;
    logic            starve;
    logic            pref;

    assign bit_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
    // lrclk leads the slot by one bit, so it is derived from the bit about to start
    assign lr_nxt  = (bit_nxt >= LR_LO) && (bit_nxt <= LR_HI);

    always_comb begin
        frame_end = ((state == RUN) || (state == DRAIN)) && bclk &&
                    (div_cnt == DIV_LAST) && (bit_cnt == BIT_LAST);
        decide    = rst_n && ((state == PRIME) || (frame_end && enable));
        pref      = ~last_grant;
        grant     = 1'b0;
        xfer      = 1'b0;
        case (mode)
            2'd0: begin
                grant = ~s0_valid & s1_valid;
                xfer  = s0_valid | s1_valid;
            end
            2'd1: begin
                grant = 1'b1;
                xfer  = s1_valid;
            end
            2'd2: begin
                grant = pref;
                if (!(pref ? s1_valid : s0_valid) && (pref ? s0_valid : s1_valid))
                    grant = ~pref;
                xfer  = s0_valid | s1_valid;
            end
            default: ;
        endcase
        starve = decide && (mode != 2'd3) && !xfer;
    end

    assign s0_ready = decide && xfer && !grant;
    assign s1_ready = decide && xfer && grant;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            bclk         <= 1'b0;
            lrclk        <= 1'b0;
            bit_strobe   <= 1'b0;
            tx_load      <= 1'b0;
            tx_left      <= '0;
            tx_right     <= '0;
            tx_src       <= 1'b0;
            active       <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
            last_grant   <= 1'b1;
        end else begin
            bit_strobe <= 1'b0;
            tx_load    <= decide;

            if (clr_stats) begin
                underrun     <= starve;
                underrun_cnt <= starve ? 16'd1 : 16'd0;
            end else if (starve) begin
                underrun <= 1'b1;
                if (underrun_cnt != 16'hFFFF)
                    underrun_cnt <= underrun_cnt + 16'd1;
            end

            if (decide) begin
                tx_src <= grant;
                if (xfer) begin
                    tx_left    <= grant ? s1_left  : s0_left;
                    tx_right   <= grant ? s1_right : s0_right;
                    last_grant <= grant;
                end else if ((mode == 2'd3) || !HOLD_LAST) begin
                    tx_left  <= '0;
                    tx_right <= '0;
                end
            end

            case (state)
                IDLE: begin
                    if (enable)
                        state <= PRIME;
                end
                PRIME: begin
                    state   <= RUN;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    bclk    <= 1'b0;
                    lrclk   <= 1'b0;
                    active  <= 1'b1;
                end
                default: begin
                    // the frame-end step also lands bclk low and bit_cnt at 0 for IDLE
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        bclk    <= ~bclk;
                        if (bclk) begin
                            bit_strobe <= 1'b1;
                            bit_cnt    <= bit_nxt;
                            lrclk      <= lr_nxt;
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                    if (frame_end && !enable) begin
                        state  <= IDLE;
                        active <= 1'b0;
                    end else begin
                        state <= enable ? RUN : DRAIN;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_tx_scheduler.sv
// Directed bench for i2s_tx_scheduler: a frame-time model checked every cycle plus literal expectations.
module tb_i2s_tx_scheduler;

    localparam int DATA_W  = 32;
    localparam int CLK_DIV = 4;
    localparam int FRAME   = 2 * DATA_W * 2 * CLK_DIV;

    logic              clk = 1'b0;
    logic              rst_n, enable, s0_valid, s1_valid, clr_stats;
    logic [1:0]        mode;
    logic [DATA_W-1:0] s0_left, s0_right, s1_left, s1_right;
    logic              s0_ready, s1_ready, bclk, lrclk, bit_strobe, tx_load, tx_src, active, underrun;
    logic [DATA_W-1:0] tx_left, tx_right;
    logic [15:0]       underrun_cnt;

    int total = 0;
    int bad   = 0;

    i2s_tx_scheduler #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .HOLD_LAST(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_left(s0_left), .s0_right(s0_right),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_left(s1_left), .s1_right(s1_right),
        .clr_stats(clr_stats), .bclk(bclk), .lrclk(lrclk), .bit_strobe(bit_strobe),
        .tx_load(tx_load), .tx_left(tx_left), .tx_right(tx_right), .tx_src(tx_src),
        .active(active), .underrun(underrun), .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    // Model state: running flag plus clk-time offset within the frame.
    logic              m_run = 1'b0, m_prime = 1'b0, m_lg = 1'b1, chk_en = 1'b0;
    int                m_t = 0;
    logic              e_bclk, e_lr, e_strobe, e_load, e_src, e_active, e_under;
    logic [15:0]       e_cnt;
    logic [DATA_W-1:0] e_left, e_right;

    function automatic void arb(input logic [1:0] md, input logic v0, input logic v1,
                                input logic lg, output logic g, output logic x);
        g = 1'b0;
        x = 1'b0;
        case (md)
            2'd0: begin x = v0 | v1; g = !v0 && v1; end
            2'd1: begin x = v1; g = 1'b1; end
            2'd2: begin
                x = v0 | v1;
                g = !lg;
                if (!(g ? v1 : v0)) g = !g;
                if (!x) g = !lg;
            end
            default: ;
        endcase
    endfunction

    function automatic logic model_decide();
        return rst_n && (m_prime || (m_run && m_t == FRAME - 1 && enable));
    endfunction

    always @(posedge clk) begin
        logic dec, g, x, und;
        int   bitn;
        chk_en = 1'b1;
        dec = model_decide();
        arb(mode, s0_valid, s1_valid, m_lg, g, x);
        und = dec && mode != 2'd3 && !x;
        if (!rst_n) begin
            m_run = 0; m_prime = 0; m_t = 0; m_lg = 1;
            e_load = 0; e_src = 0; e_under = 0; e_cnt = 0; e_left = 0; e_right = 0; e_strobe = 0;
        end else begin
            if (clr_stats) begin
                e_under = und;
                e_cnt   = und ? 16'd1 : 16'd0;
            end else if (und) begin
                e_under = 1;
                if (e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
            end
            e_load = dec;
            if (dec) begin
                e_src = g;
                if (x) begin
                    e_left  = g ? s1_left : s0_left;
                    e_right = g ? s1_right : s0_right;
                    m_lg    = g;
                end else begin
                    e_left  = '0;
                    e_right = '0;
                end
            end
            e_strobe = 0;
            if (m_prime) begin
                m_prime = 0; m_run = 1; m_t = 0;
            end else if (m_run) begin
                m_t = (m_t + 1) % FRAME;
                e_strobe = (m_t % (2 * CLK_DIV)) == 0;
                if (m_t == 0 && !enable) m_run = 0;
            end else if (enable) begin
                m_prime = 1;
            end
        end
        e_active = m_run;
        bitn     = m_t / (2 * CLK_DIV);
        e_bclk   = m_run && ((m_t / CLK_DIV) % 2 == 1);
        e_lr     = m_run && bitn >= DATA_W - 1 && bitn <= 2 * DATA_W - 2;
    end

    int   ready_cnt = 0, load_cnt = 0;
    logic s1_seen = 1'b0;

    always @(negedge clk) begin
        logic        dec, g, x;
        logic [88:0] got, exp;
        if (chk_en) begin
            dec = model_decide();
            arb(mode, s0_valid, s1_valid, m_lg, g, x);
            got = {bclk, lrclk, bit_strobe, tx_load, tx_src, active, underrun, s0_ready, s1_ready,
                   underrun_cnt, tx_left, tx_right};
            exp = {e_bclk, e_lr, e_strobe, e_load, e_src, e_active, e_under,
                   dec && x && !g, dec && x && g, e_cnt, e_left, e_right};
            total++;
            if (got !== exp) begin
                bad++;
                if (bad <= 20) $display("FAIL cycle_model t=%0t got=%h want=%h", $time, got, exp);
            end
            ready_cnt += int'(s0_ready) + int'(s1_ready);
            load_cnt  += int'(tx_load);
            if (s1_ready) s1_seen = 1'b1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    task automatic wait_load(input int budget, output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!tx_load && n < budget);
        if (!tx_load) begin
            total++;
            bad++;
            $display("FAIL wait_load timeout got=0 want=1 after %0d cycles", n);
        end
    endtask

    initial begin
        int n, r0, l0;
        rst_n = 0; enable = 1; mode = 2'd0; clr_stats = 0;
        s0_valid = 1; s1_valid = 1;
        s0_left = 32'h11111111; s0_right = 32'h22222222;
        s1_left = 32'h33333333; s1_right = 32'h44444444;

        // reset held with enable and both sources valid
        repeat (3) begin
            tick(1);
            chk("reset_ready", {s0_ready, s1_ready}, 0);
            chk("reset_outs", {bclk, lrclk, bit_strobe, tx_load, active, underrun_cnt, tx_left}, 0);
        end

        // priority mode, first load two cycles after release
        s1_seen = 0;
        rst_n = 1;
        tick(2);
        chk("first_load", tx_load, 1);
        chk("first_left", tx_left, 64'h11111111);
        chk("first_right", tx_right, 64'h22222222);
        chk("first_src", tx_src, 0);
        tick(4);
        chk("bclk_high_t4", bclk, 1);
        tick(4);
        chk("bclk_fall_t8", {bclk, bit_strobe}, 2'b01);
        wait_load(600, n);
        chk("frame_spacing", 8 + n, FRAME);
        chk("s1_never_ready", s1_seen, 0);

        // round robin from reset: 0,1,0,1 with one ready per frame
        rst_n = 0; mode = 2'd2;
        tick(2);
        ready_cnt = 0;
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            wait_load(600, n);
            chk("rr_src", tx_src, 64'(i % 2));
            chk("rr_ready_count", ready_cnt, 64'(i + 1));
        end

        // starvation for three frames, then stats clears
        mode = 2'd0; s0_valid = 0; s1_valid = 0;
        for (int i = 0; i < 3; i++) wait_load(600, n);
        chk("underrun_cnt3", underrun_cnt, 3);
        chk("underrun_flag", underrun, 1);
        chk("underrun_data", {tx_left, tx_right}, 0);
        tick(10);
        clr_stats = 1;
        tick(1);
        clr_stats = 0;
        chk("clr_stats", {underrun, underrun_cnt}, 0);
        tick(FRAME - 12);
        clr_stats = 1;
        tick(1);
        clr_stats = 0;
        chk("clr_with_underrun", {tx_load, underrun, underrun_cnt}, {1'b1, 1'b1, 16'd1});

        // drain: enable dropped at bit 10 of the frame
        s0_valid = 1; s1_valid = 1;
        tick(80);
        enable = 0;
        l0 = load_cnt;
        n = 0;
        while (active && n < 600) begin
            tick(1);
            n++;
        end
        chk("drain_end_time", 80 + n, FRAME);
        chk("drain_idle_pins", {bclk, lrclk, tx_load, active}, 0);
        tick(100);
        chk("drain_no_load", load_cnt - l0, 0);

        // restart, then re-raise enable inside the drain
        enable = 1;
        wait_load(10, n);
        chk("restart_latency", n, 2);
        tick(80);
        enable = 0;
        tick(100);
        enable = 1;
        wait_load(600, n);
        chk("drain_rearm_spacing", 180 + n, FRAME);

        // reset mid-frame at bit 20
        tick(160);
        rst_n = 0;
        r0 = ready_cnt;
        tick(1);
        chk("midframe_reset", {bclk, lrclk, tx_load, active}, 0);
        chk("midframe_reset_ready", ready_cnt - r0, 0);
        rst_n = 1;
        tick(2);
        chk("post_reset_load", tx_load, 1);
        tick(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
